// File: rtl/add_seq_ctrl.sv
// Byte-serial W-bit adder built around one shared 8-bit ripple-carry adder.
// Result is valid NBYTES cycles after acceptance and held until out_ready; in_ready only in IDLE, so there is no queuing.

module fadder_8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       ci,
    output logic [7:0] s,
    output logic [7:0] c
);
    logic carry;

    // c[i] is the carry out of bit i, so c[6] is the carry into the MSB.
    always_comb begin
        s     = '0;
        c     = '0;
        carry = ci;
        for (int i = 0; i < 8; i++) begin
            s[i]  = x[i] ^ y[i] ^ carry;
            c[i]  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
            carry = c[i];
        end
    end
endmodule

module add_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    sum_sh_q, sum_sh_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [7:0]      add_s;
    logic [7:0]      add_c;
    logic [W+7:0]    shift_cat;
    logic            unused_bits;

    fadder_8 u_fadder (
        .x  (a_sh_q[7:0]),
        .y  (b_sh_q[7:0]),
        .ci (carry_q),
        .s  (add_s),
        .c  (add_c)
    );

    // New byte enters at the top; after NBYTES shifts byte k sits at [8k+7:8k].
    assign shift_cat   = {add_s, sum_sh_q};
    assign unused_bits = ^{add_c[5:0], shift_cat[7:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                carry_d  = add_c[7];
                a_sh_d   = a_sh_q >> 8;
                b_sh_d   = b_sh_q >> 8;
                sum_sh_d = shift_cat[W+7:8];
                if (cnt_q == CW'(NBYTES - 1)) begin
                    sum_d   = shift_cat[W+7:8];
                    cout_d  = add_c[7];
                    ovf_d   = add_c[6] ^ add_c[7];
                    state_d = DONE;
                end else begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: vector table for NBYTES=4 plus hand sequences for
// back-pressure, abort-by-reset and an NBYTES=1 instance.

module tb_add_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
    logic [31:0] a, b, sum;

    logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1, busy1;
    logic [7:0]  a1, b1, sum1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    add_seq_ctrl #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    typedef struct {
        logic [31:0] av;
        logic [31:0] bv;
        logic        ci;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present operands at a negedge, wait for acceptance, then count cycles to out_valid.
    task automatic run4(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1; a = av; b = bv; cin = ci;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'hCAFEF00D; cin = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic consume4();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic seen;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};

        // Reset held two cycles with in_valid asserted: nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b1;
        out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0; out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            run4(vecs[i].av, vecs[i].bv, vecs[i].ci, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd4);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
            chk($sformatf("v%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
            chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
            chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd1);
            consume4();
            chk($sformatf("v%0d_idle_out_valid", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("v%0d_idle_in_ready", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("v%0d_sum_held", i), sum, vecs[i].exp_sum);
        end

        // Back-pressure: result held while a new request waits, then the held request is taken.
        run4(32'h000000FF, 32'h00000001, 1'b0, lat);
        chk("bp_first_latency", lat, 32'd4);
        in_valid = 1'b1; a = 32'h11111111; b = 32'h11111111; cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold%0d_sum", k), sum, 32'h00000100);
            chk($sformatf("bp_hold%0d_cout", k), {31'd0, cout}, 32'd0);
            chk($sformatf("bp_hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp_hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_consumed_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = 32'h0; b = 32'h0;
        chk("bp_accepted_busy", {31'd0, busy}, 32'd1);
        chk("bp_accepted_in_ready", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        chk("bp_second_latency", lat, 32'd4);
        chk("bp_second_sum", sum, 32'h22222222);
        consume4();

        // Abort: reset lands on the second ADD cycle.
        in_valid = 1'b1; a = 32'h01020304; b = 32'h05060708; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_out_valid", {31'd0, seen}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        run4(32'h12345678, 32'h11111111, 1'b0, lat);
        chk("after_abort_latency", lat, 32'd4);
        chk("after_abort_sum", sum, 32'h23456789);
        consume4();

        // NBYTES=1 instance: single ADD cycle.
        in_valid1 = 1'b1; a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0; a1 = 8'hFF; b1 = 8'hFF;
        chk("n1_add_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("n1_add_busy", {31'd0, busy1}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("n1_out_valid", {31'd0, out_valid1}, 32'd1);
        chk("n1_sum", {24'd0, sum1}, 32'h00000000);
        chk("n1_cout", {31'd0, cout1}, 32'd1);
        chk("n1_ovf", {31'd0, ovf1}, 32'd1);
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("n1_idle_in_ready", {31'd0, in_ready1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
